// File: rtl/geo_pkg.sv
// Shared types for the shape sequencer: shape/state encodings, vertex and edge
// structs, and the edge-table selection used to feed the line engine.
package geo_pkg;

   localparam int COORD_W = 12;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      SHAPE_POINT = 2'd0,
      SHAPE_LINE  = 2'd1,
      SHAPE_TRI   = 2'd2,
      SHAPE_RSVD  = 2'd3
   } shape_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_POINT     = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } vertex_t;

   typedef struct packed {
      vertex_t a;
      vertex_t b;
   } seg_t;

   // Closed polygon walk: v0->v1, v1->v2, v2->v0.
   function automatic seg_t edge_select(input logic [1:0] idx,
                                        input vertex_t v0,
                                        input vertex_t v1,
                                        input vertex_t v2);
      seg_t s;
      case (idx)
         2'd0:    begin s.a = v0; s.b = v1; end
         2'd1:    begin s.a = v1; s.b = v2; end
         default: begin s.a = v2; s.b = v0; end
      endcase
      return s;
   endfunction

   function automatic logic [1:0] last_edge(input shape_e shape);
      return (shape == SHAPE_TRI) ? 2'd2 : 2'd0;
   endfunction

endpackage

// File: rtl/geo_shape_sequencer_if.sv
// Command and line-engine bundle of the shape sequencer; the sequencer uses the
// slave view, the command source / line engine side uses the master view.
interface geo_shape_sequencer_if;
   import geo_pkg::*;

   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_shape;
   coord_t       cmd_x0;
   coord_t       cmd_y0;
   coord_t       cmd_x1;
   coord_t       cmd_y1;
   coord_t       cmd_x2;
   coord_t       cmd_y2;
   logic         cmd_abort;
   logic         draw_busy;

   logic         le_run;
   logic         le_pass_thru_a;
   coord_t       le_aX;
   coord_t       le_aY;
   coord_t       le_bX;
   coord_t       le_bY;
   logic         le_busy;
   logic         le_line_complete;

   logic         busy;
   logic         shape_done;
   logic [1:0]   edge_idx;

   modport slave (
      input  cmd_valid, cmd_shape, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
      input  cmd_abort, draw_busy, le_busy, le_line_complete,
      output cmd_ready, le_run, le_pass_thru_a, le_aX, le_aY, le_bX, le_bY,
      output busy, shape_done, edge_idx
   );

   modport master (
      output cmd_valid, cmd_shape, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
      output cmd_abort, draw_busy, le_busy, le_line_complete,
      input  cmd_ready, le_run, le_pass_thru_a, le_aX, le_aY, le_bX, le_bY,
      input  busy, shape_done, edge_idx
   );

endinterface

// File: rtl/geo_shape_sequencer.sv
// Walks point/line/triangle commands into line-engine requests, one edge at a time.
// Outputs decode directly from registered state; coordinates are pure routing.
module geo_shape_sequencer
   import geo_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   geo_shape_sequencer_if.slave bus
);

   state_e     state;
   state_e     state_d;
   shape_e     shape_q;
   vertex_t    v0_q;
   vertex_t    v1_q;
   vertex_t    v2_q;
   logic [1:0] edge_idx_q;
   logic [1:0] edge_idx_d;
   seg_t       seg_q;
   seg_t       seg_d;
   logic       latch_cmd;

   vertex_t    cmd_v0;
   vertex_t    cmd_v1;
   vertex_t    cmd_v2;
   shape_e     cmd_shape;
   logic       abort_hit;

   assign cmd_v0    = '{x: bus.cmd_x0, y: bus.cmd_y0};
   assign cmd_v1    = '{x: bus.cmd_x1, y: bus.cmd_y1};
   assign cmd_v2    = '{x: bus.cmd_x2, y: bus.cmd_y2};
   assign cmd_shape = shape_e'(bus.cmd_shape);

   // DONE is already terminating, so an abort there must not re-pulse shape_done.
   assign abort_hit = bus.cmd_abort && (state != ST_IDLE) && (state != ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         shape_q    <= SHAPE_POINT;
         v0_q       <= '0;
         v1_q       <= '0;
         v2_q       <= '0;
         edge_idx_q <= '0;
         seg_q      <= '0;
      end else begin
         state      <= state_d;
         edge_idx_q <= edge_idx_d;
         seg_q      <= seg_d;
         if (latch_cmd) begin
            shape_q <= cmd_shape;
            v0_q    <= cmd_v0;
            v1_q    <= cmd_v1;
            v2_q    <= cmd_v2;
         end
      end
   end

   always_comb begin
      state_d    = state;
      edge_idx_d = edge_idx_q;
      seg_d      = seg_q;
      latch_cmd  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               latch_cmd = 1'b1;
               case (cmd_shape)
                  SHAPE_POINT: begin
                     seg_d   = edge_select(2'd0, cmd_v0, cmd_v1, cmd_v2);
                     state_d = ST_POINT;
                  end
                  SHAPE_LINE, SHAPE_TRI: begin
                     edge_idx_d = 2'd0;
                     seg_d      = edge_select(2'd0, cmd_v0, cmd_v1, cmd_v2);
                     state_d    = ST_ISSUE;
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end
         ST_ISSUE: state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (bus.le_busy && !bus.draw_busy)
               state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // Completion only counts on an unstalled cycle; WAIT_DONE itself
            // gives the required le_run gap before the next edge.
            if (bus.le_line_complete && !bus.draw_busy) begin
               if (edge_idx_q != last_edge(shape_q)) begin
                  edge_idx_d = edge_idx_q + 2'd1;
                  seg_d      = edge_select(edge_idx_q + 2'd1, v0_q, v1_q, v2_q);
                  state_d    = ST_ISSUE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_POINT: begin
            if (!bus.draw_busy)
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (abort_hit) begin
         state_d    = ST_DONE;
         edge_idx_d = edge_idx_q;
         seg_d      = seg_q;
      end
   end

   assign bus.cmd_ready      = (state == ST_IDLE);
   assign bus.busy           = (state != ST_IDLE);
   assign bus.le_run         = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
   assign bus.le_pass_thru_a = (state == ST_POINT);
   assign bus.shape_done     = (state == ST_DONE);
   assign bus.edge_idx       = edge_idx_q;
   assign bus.le_aX          = seg_q.a.x;
   assign bus.le_aY          = seg_q.a.y;
   assign bus.le_bX          = seg_q.b.x;
   assign bus.le_bY          = seg_q.b.y;

endmodule
